// File: rtl/adc_sar_ctrl_if.sv
// Analog front-end / core handshake bundle for the SAR ADC controller.
// slave modport is the controller side; master is the front end / core side.
interface adc_sar_ctrl_if #(
  parameter int unsigned RES = 10
);
  logic           start;
  logic           cmp;
  logic           smpl;
  logic [RES-1:0] dac;
  logic           busy;
  logic           done;
  logic [RES-1:0] dout;

  modport master (output start, cmp, input smpl, dac, busy, done, dout);
  modport slave  (input start, cmp, output smpl, dac, busy, done, dout);
endinterface

// File: rtl/adc_sar_ctrl.sv
// Successive-approximation ADC controller: sample phase, binary search on CMP, result + DONE strobe.
// Optional 4-pass averaging enabled by defining ADC_SAR_AVG_EN.
module adc_sar_ctrl #(
  parameter int unsigned RES        = 10,
  parameter int unsigned SAMPLE_CYC = 4
) (
  input logic           clk,
  input logic           rst,
  adc_sar_ctrl_if.slave bus
);
  localparam int unsigned BW = $clog2(RES);
  localparam int unsigned SW = $clog2(SAMPLE_CYC + 1);
  localparam logic [RES-1:0] MSB = {1'b1, {(RES-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV} state_t;

  state_t         state;
  logic [SW-1:0]  scnt;
  logic [BW-1:0]  bit_idx;
  logic [RES-1:0] res;
  logic [RES-1:0] res_n;
  logic [RES-1:0] trial;
  logic [RES-1:0] result;

`ifdef ADC_SAR_AVG_EN
  logic [1:0]     pass;
  logic [RES+1:0] acc;
  logic [RES+1:0] acc_n;
`endif

  always_comb begin
    res_n          = res;
    res_n[bit_idx] = bus.cmp;
    trial          = res_n;
    if (bit_idx != '0) trial[bit_idx - BW'(1)] = 1'b1;
`ifdef ADC_SAR_AVG_EN
    acc_n  = acc + {2'b00, res_n};
    result = acc_n[RES+1:2];
`else
    result = res_n;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      scnt     <= '0;
      bit_idx  <= '0;
      res      <= '0;
      bus.smpl <= 1'b0;
      bus.dac  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.dout <= '0;
`ifdef ADC_SAR_AVG_EN
      pass     <= '0;
      acc      <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SAMPLE;
            scnt     <= '0;
            bus.smpl <= 1'b1;
            bus.busy <= 1'b1;
`ifdef ADC_SAR_AVG_EN
            pass     <= '0;
            acc      <= '0;
`endif
          end
        end
        SAMPLE: begin
          if (scnt == SW'(SAMPLE_CYC - 1)) begin
            state    <= CONV;
            bus.smpl <= 1'b0;
            bus.dac  <= MSB;
            bit_idx  <= BW'(RES - 1);
            res      <= '0;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        CONV: begin
          res <= res_n;
          if (bit_idx != '0) begin
            bus.dac <= trial;
            bit_idx <= bit_idx - BW'(1);
          end else begin
`ifdef ADC_SAR_AVG_EN
            if (pass != 2'd3) begin
              state    <= SAMPLE;
              scnt     <= '0;
              bus.smpl <= 1'b1;
              bus.dac  <= '0;
              acc      <= acc_n;
              pass     <= pass + 2'd1;
            end else
`endif
            begin
              bus.dout <= result;
              bus.done <= 1'b1;
              bus.dac  <= '0;
              // A START on the finishing edge chains straight into the next
              // sample phase so back-to-back conversions have no idle gap.
              if (bus.start) begin
                state    <= SAMPLE;
                scnt     <= '0;
                bus.smpl <= 1'b1;
`ifdef ADC_SAR_AVG_EN
                pass     <= '0;
                acc      <= '0;
`endif
              end else begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Scoreboard bench for adc_sar_ctrl: ideal comparator model, directed vectors.
module tb_adc_sar_ctrl;
  localparam int unsigned RES = 10;
  localparam int unsigned SC  = 4;
`ifdef ADC_SAR_AVG_EN
  localparam int LAT = 4 * (SC + RES);
`else
  localparam int LAT = SC + RES;
`endif

  typedef struct {
    int dout;
    int cyc;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic [9:0] vin = '0;
  int       cyc = 0;
  int       vectors = 0;
  int       miscompares = 0;
  exp_t     sb[$];

  adc_sar_ctrl_if #(.RES(RES)) bus ();

  adc_sar_ctrl #(.RES(RES), .SAMPLE_CYC(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb bus.cmp = (vin >= bus.dac);

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout", int'(bus.dout), e.dout);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Returns at the negedge following the START edge (cyc == E0).
  task automatic start_conv(input logic [9:0] v, input bit expect_done);
    @(negedge clk);
    vin = v;
    bus.start = 1'b1;
    if (expect_done) sb.push_back('{dout: int'(v), cyc: cyc + 1 + LAT});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_smpl", bus.smpl, 0);
    check("rst_dac",  bus.dac,  0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dout", bus.dout, 0);
    rst = 1'b0;

    // 1: basic conversion, sample window width
    start_conv(10'h2A5, 1'b1);
    for (int unsigned i = 0; i < SC; i++) begin
      check("smpl_high", bus.smpl, 1);
      check("dac_sample", bus.dac, 0);
      check("busy_sample", bus.busy, 1);
      @(negedge clk);
    end
    check("smpl_low_conv", bus.smpl, 0);
    check("dac_first_trial", bus.dac, 'h200);
    wait_drain(LAT + 20);

    // 2: extremes, with DAC trial sequence for full scale
    start_conv(10'h000, 1'b1);
    wait_drain(LAT + 20);
    start_conv(10'h3FF, 1'b1);
    repeat (SC) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("dac_trial", bus.dac, (32'h3FF << (9 - k)) & 32'h3FF);
      @(negedge clk);
    end
    wait_drain(LAT + 20);

    // 3: START while busy is ignored
    start_conv(10'h155, 1'b1);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(LAT + 20);
    repeat (LAT + 5) @(negedge clk);
    check("idle_after_ignored", bus.busy, 0);

    // 4: START held through the DONE cycle -> back-to-back
    @(negedge clk);
    vin = 10'h0F0;
    bus.start = 1'b1;
    e0 = cyc + 1;
    sb.push_back('{dout: 'h0F0, cyc: e0 + LAT});
    sb.push_back('{dout: 'h0F0, cyc: e0 + 2 * LAT});
    repeat (LAT + 1) @(negedge clk);
    check("b2b_busy", bus.busy, 1);
    check("b2b_smpl", bus.smpl, 1);
    bus.start = 1'b0;
    wait_drain(LAT + 20);

    // 5: reset mid-conversion aborts
    start_conv(10'h2A5, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_smpl", bus.smpl, 0);
    check("abort_dac",  bus.dac,  0);
    check("abort_busy", bus.busy, 0);
    check("abort_dout", bus.dout, 0);
    rst = 1'b0;
    repeat (LAT + 10) @(negedge clk);
    check("abort_no_restart", bus.busy, 0);

`ifdef ADC_SAR_AVG_EN
    // 6: per-pass input changes, truncating average
    @(negedge clk);
    vin = 10'h100;
    bus.start = 1'b1;
    e0 = cyc + 1;
    sb.push_back('{dout: 'h101, cyc: e0 + LAT});
    @(negedge clk);
    bus.start = 1'b0;
    for (int p = 1; p < 4; p++) begin
      repeat (SC + RES) @(negedge clk);
      vin = 10'(10'h100 + p);
    end
    wait_drain(LAT + 20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
